// File: rtl/fractal_video_pkg.sv
// fractal_video_pkg
// Shared constants and types for the fractal pixel generator video path.
//   AXIS_DATA_W / AXIS_KEEP_W : width of the packed AXI4-Stream video word
//   PIXEL_BYTES               : bytes per RGB pixel
//   X_SIZE / Y_SIZE           : active frame geometry
//   pack_state_t              : packer FSM states
//   keep_for_count()          : low-lane tkeep mask for a residual byte count
package fractal_video_pkg;

    localparam int AXIS_DATA_W = 32;
    localparam int AXIS_KEEP_W = AXIS_DATA_W / 8;
    localparam int PIXEL_BYTES = 3;
    localparam int X_SIZE      = 640;
    localparam int Y_SIZE      = 480;

    typedef enum logic {
        PACK  = 1'b0,
        FLUSH = 1'b1
    } pack_state_t;

    // Mask with the lowest 'count' byte lanes set.
    function automatic logic [AXIS_KEEP_W-1:0] keep_for_count(input logic [1:0] count);
        logic [AXIS_KEEP_W-1:0] mask;
        case (count)
            2'd0:    mask = 4'h0;
            2'd1:    mask = 4'h1;
            2'd2:    mask = 4'h3;
            default: mask = 4'h7;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/rgb_word_packer_if.sv
// rgb_word_packer_if
// Bundles the pixel input handshake and the AXI4-Stream video output of the
// RGB word packer.
//   r/g/b, valid, sof, eol    : pixel from the generator
//   in_stream_ready           : packer accepts the pixel this cycle
//   out_stream_t*             : packed 32-bit AXI4-Stream video word
//   misalign                  : one-cycle pulse, sof arrived with bytes pending
// Modports: master = pixel source / stream sink side, slave = the packer.
interface rgb_word_packer_if;
    import fractal_video_pkg::*;

    logic [7:0]             r;
    logic [7:0]             g;
    logic [7:0]             b;
    logic                   valid;
    logic                   sof;
    logic                   eol;
    logic                   in_stream_ready;

    logic [AXIS_DATA_W-1:0] out_stream_tdata;
    logic [AXIS_KEEP_W-1:0] out_stream_tkeep;
    logic                   out_stream_tlast;
    logic                   out_stream_tuser;
    logic                   out_stream_tvalid;
    logic                   out_stream_tready;

    logic                   misalign;

    modport master (
        output r, g, b, valid, sof, eol, out_stream_tready,
        input  in_stream_ready, out_stream_tdata, out_stream_tkeep,
               out_stream_tlast, out_stream_tuser, out_stream_tvalid, misalign
    );

    modport slave (
        input  r, g, b, valid, sof, eol, out_stream_tready,
        output in_stream_ready, out_stream_tdata, out_stream_tkeep,
               out_stream_tlast, out_stream_tuser, out_stream_tvalid, misalign
    );

endinterface

// File: rtl/axis_out_reg.sv
// axis_out_reg
// Single-entry AXI4-Stream holding register.
//   aclk, areset          : clock, synchronous active-high reset
//   load, d_*             : word to capture (only honoured when can_load)
//   tready                : downstream accepts the held word
//   tdata/tkeep/tlast/tuser/tvalid : registered stream outputs
//   can_load              : register is empty or being drained this cycle
module axis_out_reg
    import fractal_video_pkg::*;
(
    input  logic                   aclk,
    input  logic                   areset,
    input  logic                   load,
    input  logic [AXIS_DATA_W-1:0] d_data,
    input  logic [AXIS_KEEP_W-1:0] d_keep,
    input  logic                   d_last,
    input  logic                   d_user,
    input  logic                   tready,
    output logic [AXIS_DATA_W-1:0] tdata,
    output logic [AXIS_KEEP_W-1:0] tkeep,
    output logic                   tlast,
    output logic                   tuser,
    output logic                   tvalid,
    output logic                   can_load
);

    // A drain and a load in the same cycle hand over without a bubble.
    assign can_load = !tvalid || tready;

    // Payload only changes on a load, so it stays frozen while stalled.
    always_ff @(posedge aclk) begin
        if (areset) begin
            tdata  <= '0;
            tkeep  <= '0;
            tlast  <= 1'b0;
            tuser  <= 1'b0;
            tvalid <= 1'b0;
        end else if (load && can_load) begin
            tdata  <= d_data;
            tkeep  <= d_keep;
            tlast  <= d_last;
            tuser  <= d_user;
            tvalid <= 1'b1;
        end else if (tready) begin
            tvalid <= 1'b0;
        end
    end

endmodule

// File: rtl/rgb_word_packer.sv
// rgb_word_packer
// Packs 24-bit RGB pixels densely into 32-bit AXI4-Stream words, four pixels
// to three words, stream byte k on lane k mod 4.
//   PIXEL_ORDER_RGB : 0 = b,g,r byte order (b lowest), 1 = r,g,b
//   aclk, areset    : clock, synchronous active-high reset
//   bus             : pixel input handshake and AXIS video output (slave side)
// Unaligned line ends cost one FLUSH cycle that emits the leftover bytes.
module rgb_word_packer
    import fractal_video_pkg::*;
#(
    parameter bit PIXEL_ORDER_RGB = 1'b0
)
(
    input  logic               aclk,
    input  logic               areset,
    rgb_word_packer_if.slave   bus
);

    pack_state_t            state;
    logic [23:0]            res;
    logic [1:0]             n;
    logic                   pend_user;
    logic                   misalign_q;

    logic [23:0]            pix;
    logic [1:0]             n_eff;
    logic [47:0]            cat;
    logic                   tuser_now;
    logic                   accept;
    logic                   can_load;
    logic [AXIS_DATA_W-1:0] flush_data;

    logic                   load;
    logic [AXIS_DATA_W-1:0] ld_data;
    logic [AXIS_KEEP_W-1:0] ld_keep;
    logic                   ld_last;
    logic                   ld_user;

    // Pixel bytes in stream order, first stream byte in bits [7:0].
    assign pix = PIXEL_ORDER_RGB ? {bus.b, bus.g, bus.r} : {bus.r, bus.g, bus.b};

    // The n==0 && !eol case never produces a word, so it can be taken even
    // while the output register is stalled.
    assign bus.in_stream_ready = !areset && (state == PACK) &&
                                 (can_load || (n == 2'd0 && !bus.eol));
    assign accept       = bus.valid && bus.in_stream_ready;
    assign bus.misalign = misalign_q;

    // Byte-select mux: a sof pixel discards residual bytes and starts at
    // lane 0, otherwise it is appended after the n residual bytes.
    always_comb begin
        n_eff     = bus.sof ? 2'd0 : n;
        tuser_now = bus.sof || pend_user;
        case (n_eff)
            2'd0:    cat = {24'h0, pix};
            2'd1:    cat = {16'h0, pix, res[7:0]};
            2'd2:    cat = {8'h0, pix, res[15:0]};
            default: cat = {pix, res};
        endcase
        case (n)
            2'd1:    flush_data = {24'h0, res[7:0]};
            2'd2:    flush_data = {16'h0, res[15:0]};
            2'd3:    flush_data = {8'h0, res};
            default: flush_data = '0;
        endcase
    end

    // Selects what, if anything, goes into the output register this cycle.
    always_comb begin
        load    = 1'b0;
        ld_data = '0;
        ld_keep = '0;
        ld_last = 1'b0;
        ld_user = 1'b0;
        if (state == FLUSH) begin
            if (can_load) begin
                load    = 1'b1;
                ld_data = flush_data;
                ld_keep = keep_for_count(n);
                ld_last = 1'b1;
                ld_user = pend_user;
            end
        end else if (accept) begin
            if (n_eff != 2'd0) begin
                load    = 1'b1;
                ld_data = cat[31:0];
                ld_keep = 4'hF;
                ld_last = bus.eol && (n_eff == 2'd1);
                ld_user = tuser_now;
            end else if (bus.eol) begin
                load    = 1'b1;
                ld_data = {8'h0, pix};
                ld_keep = 4'h7;
                ld_last = 1'b1;
                ld_user = tuser_now;
            end
        end
    end

    // Residual store and PACK/FLUSH sequencing. A long line end leaves 1 or 2
    // bytes behind, which FLUSH sends once the output register frees up.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state      <= PACK;
            res        <= '0;
            n          <= 2'd0;
            pend_user  <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= accept && bus.sof && (n != 2'd0);
            case (state)
                PACK: begin
                    if (accept) begin
                        if (n_eff == 2'd0 && !bus.eol) begin
                            res       <= pix;
                            n         <= 2'd3;
                            pend_user <= tuser_now;
                        end else if (n_eff == 2'd0) begin
                            res       <= '0;
                            n         <= 2'd0;
                            pend_user <= 1'b0;
                        end else begin
                            res       <= {8'h0, cat[47:32]};
                            n         <= n_eff - 2'd1;
                            pend_user <= 1'b0;
                            if (bus.eol && n_eff != 2'd1) begin
                                state <= FLUSH;
                            end
                        end
                    end
                end
                FLUSH: begin
                    if (can_load) begin
                        res       <= '0;
                        n         <= 2'd0;
                        pend_user <= 1'b0;
                        state     <= PACK;
                    end
                end
                default: state <= PACK;
            endcase
        end
    end

    axis_out_reg u_out_reg (
        .aclk     (aclk),
        .areset   (areset),
        .load     (load),
        .d_data   (ld_data),
        .d_keep   (ld_keep),
        .d_last   (ld_last),
        .d_user   (ld_user),
        .tready   (bus.out_stream_tready),
        .tdata    (bus.out_stream_tdata),
        .tkeep    (bus.out_stream_tkeep),
        .tlast    (bus.out_stream_tlast),
        .tuser    (bus.out_stream_tuser),
        .tvalid   (bus.out_stream_tvalid),
        .can_load (can_load)
    );

endmodule

// File: tb/tb_rgb_word_packer.sv
// tb_rgb_word_packer
// Scoreboard bench for rgb_word_packer (PIXEL_ORDER_RGB = 0). Accepted pixels
// feed a byte-queue model that pushes expected words; a negedge monitor pops
// and compares every transferred word, plus misalign, latency and stall hold.
module tb_rgb_word_packer;
    import fractal_video_pkg::*;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
        logic        user;
    } word_t;

    logic aclk   = 1'b0;
    logic areset = 1'b1;

    rgb_word_packer_if bus();

    rgb_word_packer #(.PIXEL_ORDER_RGB(1'b0)) dut (
        .aclk   (aclk),
        .areset (areset),
        .bus    (bus)
    );

    word_t       exp_q[$];
    logic [7:0]  byte_q[$];
    logic [31:0] word_log[$];
    bit          pend_user   = 1'b0;
    int          errors      = 0;
    int          checks      = 0;
    int          stalls      = 0;
    int          word_count  = 0;
    int          last_count  = 0;
    int          mis_count   = 0;
    bit          exp_mis     = 1'b0;
    bit          exp_tv      = 1'b0;
    bit          rst_prev    = 1'b0;
    bit          prev_stall  = 1'b0;
    word_t       prev_word;
    word_t       mon_word;
    int          tready_mode = 0;
    logic [3:0]  tready_pat  = 4'b1001;
    int          pat_idx     = 0;

    always #5 aclk = ~aclk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model: a plain byte FIFO; every 4 bytes make a word, a line
    // end sends whatever is left as a short final word.
    task automatic model_accept(input logic [7:0] r_in, input logic [7:0] g_in,
                                input logic [7:0] b_in, input logic sof_in, input logic eol_in);
        word_t w;
        bit    immediate;
        immediate = 1'b0;
        if (sof_in) begin
            exp_mis = (byte_q.size() != 0);
            byte_q.delete();
            pend_user = 1'b1;
        end
        byte_q.push_back(b_in);
        byte_q.push_back(g_in);
        byte_q.push_back(r_in);
        while (byte_q.size() >= 4) begin
            w.data = {byte_q[3], byte_q[2], byte_q[1], byte_q[0]};
            repeat (4) void'(byte_q.pop_front());
            w.keep = 4'hF;
            w.last = eol_in && (byte_q.size() == 0);
            w.user = pend_user;
            pend_user = 1'b0;
            exp_q.push_back(w);
            immediate = 1'b1;
        end
        if (eol_in && byte_q.size() > 0) begin
            w.data = '0;
            w.keep = '0;
            foreach (byte_q[i]) begin
                w.data[8*i +: 8] = byte_q[i];
                w.keep[i]        = 1'b1;
            end
            w.last = 1'b1;
            w.user = pend_user;
            pend_user = 1'b0;
            byte_q.delete();
            exp_q.push_back(w);
            immediate = 1'b1;
        end
        exp_tv = immediate;
    endtask

    // Downstream tready generator: constant, random, or the 1,0,0,1 pattern.
    always begin
        @(posedge aclk);
        #1;
        case (tready_mode)
            1: bus.out_stream_tready = 1'($urandom_range(0, 1));
            2: begin
                bus.out_stream_tready = tready_pat[pat_idx];
                pat_idx = (pat_idx + 1) % 4;
            end
            default: bus.out_stream_tready = 1'b1;
        endcase
    end

    // Monitor: the negedge view decides both handshakes of the next edge.
    always @(negedge aclk) begin
        if (areset) begin
            checkOutput("ready_in_reset", 32'(bus.in_stream_ready), 32'd0);
            if (rst_prev) begin
                checkOutput("reset_tvalid", 32'(bus.out_stream_tvalid), 32'd0);
                checkOutput("reset_tdata", bus.out_stream_tdata, 32'd0);
                checkOutput("reset_ctrl", {26'h0, bus.out_stream_tkeep, bus.out_stream_tlast,
                            bus.out_stream_tuser}, 32'd0);
                checkOutput("reset_misalign", 32'(bus.misalign), 32'd0);
            end
            exp_q.delete();
            byte_q.delete();
            pend_user  = 1'b0;
            exp_mis    = 1'b0;
            exp_tv     = 1'b0;
            prev_stall = 1'b0;
            rst_prev   = 1'b1;
        end else begin
            rst_prev = 1'b0;
            if (exp_tv) checkOutput("latency_tvalid", 32'(bus.out_stream_tvalid), 32'd1);
            checkOutput("misalign", 32'(bus.misalign), 32'(exp_mis));
            if (bus.misalign) mis_count++;
            if (prev_stall) begin
                checkOutput("stall_tvalid", 32'(bus.out_stream_tvalid), 32'd1);
                checkOutput("stall_tdata", bus.out_stream_tdata, prev_word.data);
                checkOutput("stall_ctrl", {26'h0, bus.out_stream_tkeep, bus.out_stream_tlast,
                            bus.out_stream_tuser}, {26'h0, prev_word.keep, prev_word.last,
                            prev_word.user});
            end
            if (bus.out_stream_tvalid && bus.out_stream_tready) begin
                word_count++;
                if (bus.out_stream_tlast) last_count++;
                word_log.push_back(bus.out_stream_tdata);
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_word_tvalid", 32'(bus.out_stream_tvalid), 32'd0);
                end else begin
                    mon_word = exp_q.pop_front();
                    checkOutput("word_tdata", bus.out_stream_tdata, mon_word.data);
                    checkOutput("word_tkeep", 32'(bus.out_stream_tkeep), 32'(mon_word.keep));
                    checkOutput("word_tlast", 32'(bus.out_stream_tlast), 32'(mon_word.last));
                    checkOutput("word_tuser", 32'(bus.out_stream_tuser), 32'(mon_word.user));
                end
            end
            prev_stall = bus.out_stream_tvalid && !bus.out_stream_tready;
            prev_word  = {bus.out_stream_tdata, bus.out_stream_tkeep,
                          bus.out_stream_tlast, bus.out_stream_tuser};
            exp_mis = 1'b0;
            exp_tv  = 1'b0;
            if (bus.valid && bus.in_stream_ready)
                model_accept(bus.r, bus.g, bus.b, bus.sof, bus.eol);
            if (bus.valid && !bus.in_stream_ready) stalls++;
        end
    end

    // Presents one pixel until accepted; called and returns at posedge+1.
    task automatic applyStimulus(input logic [7:0] r_in, input logic [7:0] g_in,
                                 input logic [7:0] b_in, input logic sof_in, input logic eol_in);
        int waited;
        waited    = 0;
        bus.r     = r_in;
        bus.g     = g_in;
        bus.b     = b_in;
        bus.sof   = sof_in;
        bus.eol   = eol_in;
        bus.valid = 1'b1;
        forever begin
            @(negedge aclk);
            if (bus.in_stream_ready) break;
            waited++;
            if (waited > 2000) begin
                checkOutput("accept_timeout", 32'(bus.in_stream_ready), 32'd1);
                break;
            end
        end
        @(posedge aclk);
        #1;
        bus.valid = 1'b0;
        bus.sof   = 1'b0;
        bus.eol   = 1'b0;
    endtask

    task automatic idle(input int cycles);
        repeat (cycles) begin
            @(posedge aclk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while ((exp_q.size() != 0 || bus.out_stream_tvalid) && c < 2000) begin
            @(posedge aclk);
            #1;
            c++;
        end
        if (c >= 2000) checkOutput("drain_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic send_group_of_four();
        applyStimulus(8'h01, 8'h02, 8'h03, 1'b1, 1'b0);
        applyStimulus(8'h04, 8'h05, 8'h06, 1'b0, 1'b0);
        applyStimulus(8'h07, 8'h08, 8'h09, 1'b0, 1'b0);
        applyStimulus(8'h0A, 8'h0B, 8'h0C, 1'b0, 1'b0);
    endtask

    task automatic check_group_words(input int idx, input string tag);
        if (word_log.size() < idx + 3) begin
            checkOutput({tag, "_word_count"}, 32'(word_log.size()), 32'(idx + 3));
        end else begin
            checkOutput({tag, "_w0"}, word_log[idx],     32'h06010203);
            checkOutput({tag, "_w1"}, word_log[idx + 1], 32'h08090405);
            checkOutput({tag, "_w2"}, word_log[idx + 2], 32'h0A0B0C07);
        end
    endtask

    // Directed scenarios first, then randomized lines under random tready.
    initial begin
        int idx;
        int wc0;
        int lc0;
        int len;
        bus.valid = 1'b0;
        bus.sof   = 1'b0;
        bus.eol   = 1'b0;
        bus.r     = 8'h0;
        bus.g     = 8'h0;
        bus.b     = 8'h0;
        areset    = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        areset = 1'b0;
        @(negedge aclk);
        checkOutput("ready_after_reset", 32'(bus.in_stream_ready), 32'd1);
        checkOutput("tvalid_after_reset", 32'(bus.out_stream_tvalid), 32'd0);
        @(posedge aclk);
        #1;

        idx = word_log.size();
        send_group_of_four();
        wait_drain();
        check_group_words(idx, "group4");

        idx = word_log.size();
        applyStimulus(8'h11, 8'h12, 8'h13, 1'b1, 1'b0);
        applyStimulus(8'h21, 8'h22, 8'h23, 1'b0, 1'b0);
        applyStimulus(8'h31, 8'h32, 8'h33, 1'b0, 1'b0);
        applyStimulus(8'h41, 8'h42, 8'h43, 1'b0, 1'b0);
        applyStimulus(8'h51, 8'h52, 8'h53, 1'b0, 1'b1);
        wait_drain();
        if (word_log.size() >= idx + 4)
            checkOutput("line5_tail", word_log[idx + 3], 32'h00515253);
        else
            checkOutput("line5_count", 32'(word_log.size()), 32'(idx + 4));

        stalls = 0;
        for (int i = 0; i < 6; i++)
            applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), i == 0, i == 5);
        send_group_of_four();
        wait_drain();
        checkOutput("flush_stall_cycles", 32'(stalls), 32'd1);

        mis_count = 0;
        applyStimulus(8'hA1, 8'hA2, 8'hA3, 1'b1, 1'b0);
        applyStimulus(8'hB1, 8'hB2, 8'hB3, 1'b0, 1'b0);
        idx = word_log.size();
        applyStimulus(8'hC1, 8'hC2, 8'hC3, 1'b1, 1'b0);
        applyStimulus(8'hD1, 8'hD2, 8'hD3, 1'b0, 1'b0);
        applyStimulus(8'hE1, 8'hE2, 8'hE3, 1'b0, 1'b0);
        applyStimulus(8'hF1, 8'hF2, 8'hF3, 1'b0, 1'b1);
        wait_drain();
        checkOutput("misalign_pulses", 32'(mis_count), 32'd1);
        if (word_log.size() > idx + 1)
            checkOutput("sof_lane0", 32'(word_log[idx + 1][7:0]), 32'hC3);
        else
            checkOutput("sof_word_count", 32'(word_log.size()), 32'(idx + 2));

        tready_mode = 2;
        pat_idx     = 0;
        wc0 = word_count;
        lc0 = last_count;
        for (int i = 0; i < X_SIZE; i++)
            applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), i == 0, i == X_SIZE - 1);
        wait_drain();
        checkOutput("line640_words", 32'(word_count - wc0), 32'(X_SIZE * PIXEL_BYTES / 4));
        checkOutput("line640_tlast", 32'(last_count - lc0), 32'd1);
        tready_mode = 0;
        idle(2);

        for (int i = 0; i < 6; i++)
            applyStimulus(8'($urandom), 8'($urandom), 8'($urandom), i == 0, i == 5);
        areset = 1'b1;
        idle(2);
        areset = 1'b0;
        @(negedge aclk);
        checkOutput("flush_reset_tvalid", 32'(bus.out_stream_tvalid), 32'd0);
        checkOutput("flush_reset_ready", 32'(bus.in_stream_ready), 32'd1);
        @(posedge aclk);
        #1;
        idx = word_log.size();
        send_group_of_four();
        wait_drain();
        check_group_words(idx, "post_reset");

        tready_mode = 1;
        for (int line = 0; line < 30; line++) begin
            len = $urandom_range(1, 13);
            for (int i = 0; i < len; i++) begin
                applyStimulus(8'($urandom), 8'($urandom), 8'($urandom),
                              (i == 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 19) == 0),
                              i == len - 1);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        tready_mode = 0;
        wait_drain();
        checkOutput("queue_empty_end", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard stop if something deadlocks beyond every per-wait bound.
    initial begin
        #1_000_000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog");
    end

endmodule

// File: doc/rgb_word_packer.md
# rgb_word_packer

Downstream stage of the fractal pixel generator. Accepts one 24-bit RGB pixel per handshake, with start-of-frame and end-of-line flags, and packs the pixel bytes densely into a 32-bit AXI4-Stream video output, four pixels to three words. It drives `out_stream_t*` toward the VDMA/video path. A full AXIS backpressure handshake on the output propagates to the generator through `in_stream_ready`.

## Interface
- `PIXEL_ORDER_RGB`, default 0: 0 = byte order b, g, r within a pixel (b lowest); 1 = byte order r, g, b.
- `aclk` in 1: single clock for all logic.
- `areset` in 1: synchronous, active-high reset.
- `r`, `g`, `b` in 8 each: pixel colour components.
- `valid` in 1: pixel present on `r/g/b/sof/eol`.
- `sof` in 1: pixel is the first of a frame.
- `eol` in 1: pixel is the last of a line.
- `in_stream_ready` out 1: pixel is accepted on `valid && in_stream_ready`.
- `out_stream_tdata` out 32: packed bytes; stream byte k goes to lane k mod 4.
- `out_stream_tkeep` out 4: valid byte lanes.
- `out_stream_tlast` out 1: last word of a line.
- `out_stream_tuser` out 1: first word of a frame.
- `out_stream_tvalid` out 1: word present.
- `out_stream_tready` in 1: downstream accepts the word.
- `misalign` out 1: one-cycle pulse when a `sof` pixel arrives while residual bytes are pending.

## Operation
- Internal state:
  - Residual byte store: 3 bytes, plus a count `n` in 0..3.
  - One registered output word: `tdata/tkeep/tlast/tuser/tvalid`.
  - A pending-`tuser` flag.
  - FSM with states PACK and FLUSH.
- PACK, pixel accepted:
  - The 3 pixel bytes are appended after the `n` residual bytes.
  - If `n+3 >= 4`: the lowest 4 bytes form the output word with `tkeep=4'hF`, and the new `n` is `n-1`.
  - Otherwise (`n=0`): no word is emitted and `n` becomes 3.
- `eol` on the accepted pixel:
  - If no full word was produced (`n` was 0), the 3 bytes go out as one word with `tkeep=4'h7` and `tlast=1`; `n` becomes 0.
  - If a full word was produced and the new `n=0` (`n` was 1), that word carries `tlast=1`.
  - If a full word was produced and the new `n>0` (`n` was 2 or 3), the full word has `tlast=0` and the FSM enters FLUSH.
- FLUSH:
  - Emits the residual `n` bytes in the low lanes, `tkeep = (1<<n)-1`, `tlast=1`, upper lanes zero.
  - Once that word is loaded into the output register, `n` becomes 0 and the FSM returns to PACK.
- `sof` on the accepted pixel:
  - Any residual bytes are discarded first (`misalign` pulses if `n != 0`).
  - The pixel starts at lane 0.
  - The first word emitted containing its bytes has `tuser=1`.
  - All other words have `tuser=0`.
- `in_stream_ready`:
  - Low in FLUSH and while `areset` is high.
  - In PACK: `(!out_stream_tvalid || out_stream_tready) || (n==0 && !eol)`. The `n==0 && !eol` case produces no word.
  - Combinational, from registered state and `out_stream_tready` only; no dependency on `valid`.
- Output register:
  - Loads only when empty or being drained (`tvalid && tready`) in the same cycle.
  - Holds `tdata/tkeep/tlast/tuser` stable while `tvalid && !tready`.

## Timing
- Reset values:
  - `tvalid=0`, `tdata=0`, `tkeep=0`, `tlast=0`, `tuser=0`, `misalign=0`.
  - `n=0`, state PACK, pending-`tuser` cleared, `in_stream_ready=0`.
- `in_stream_ready` is 1 the first cycle after `areset` deasserts.
- Latency: a word formed by the pixel accepted in cycle t has `tvalid=1` in cycle t+1.
- Throughput:
  - With constant `tready`, 1 pixel/cycle is sustained.
  - FLUSH costs exactly one input-stall cycle per unaligned line end.
- Simultaneous drain and load: the new word replaces the drained one in the same edge, with no bubble.
- `areset` mid-line or mid-FLUSH drops all residual bytes and any unsent output word. The next pixel starts at lane 0.
- With 640-pixel lines, `n=0` at every `eol` and FLUSH never occurs.

## Structure
- Shared package `fractal_video_pkg`:
  - `AXIS_DATA_W=32`, `PIXEL_BYTES=3`, `X_SIZE=640`, `Y_SIZE=480`.
  - State enum {PACK, FLUSH}.
- Optional sub-module `axis_out_reg`: the single-entry holding register with the load/drain rule above.
- The byte-select mux stays in `rgb_word_packer`.

## Test plan
- 4 pixels (r,g,b) = (01,02,03), (04,05,06), (07,08,09), (0A,0B,0C), `sof` on the first, `tready=1`, order 0 → words 0x06010203, 0x08090405, 0x0A0B0C07, `tkeep=F`, `tuser` 1/0/0.
- 5-pixel line, `eol` on the 5th → 3 full words then a 4th word, low 3 bytes from pixel 5, `tkeep=4'h7`, `tlast=1`.
- 6-pixel line → 4 full words, the last with `tlast=0`, then a FLUSH word `tkeep=4'h3`, `tlast=1`; `in_stream_ready` low for exactly that cycle.
- `tready` toggled 1,0,0,1 during a 640-pixel line → no word lost or duplicated, `tdata` stable while stalled, exactly 480 words, `tlast` only on word 480.
- `sof` after 2 pixels without `eol` → `misalign` pulses once, and the next word's lane 0 equals the new pixel's first byte with `tuser=1`.
- `areset` asserted during FLUSH → next cycle `tvalid=0`, `n=0`; a following 4-pixel group reproduces the first scenario's words.
